// File: rtl/sync_pkg.sv
// Shared types and sizing helpers for the debounce bank.
package sync_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_CONF_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_CONF_LO = 2'd3
    } db_state_t;

    // Bits needed to count up to cycles-1; never less than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One debounce channel: synchroniser chain, confirm FSM, registered pulses.
// Optional auto-repeat is built only when SYNC_AUTOREPEAT_EN is defined.
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int INVERT          = 1,
    parameter int REPEAT_DELAY    = 1024,
    parameter int REPEAT_RATE     = 256
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_x;
    logic                   w_s;

    db_state_t              r_state;
    db_state_t              w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;

    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_q_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;

    assign w_x = (INVERT != 0) ? ~d : d;
    assign w_s = r_sync[SYNC_STAGES-1];

    // NOTE: every clocked process uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_x};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_LOW: begin
                if (w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_CONF_HI;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_CONF_HI: begin
                if (!w_s) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_CONF_LO;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_CONF_LO: begin
                if (w_s) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
        endcase
    end

    // Pulses are derived from the next level so they coincide with its first cycle.
    always_comb begin
        w_q_nxt    = (w_state_nxt == S_HIGH) || (w_state_nxt == S_CONF_LO);
        w_rise_nxt = w_q_nxt & ~r_q;
        w_fall_nxt = ~w_q_nxt & r_q;
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;

`ifdef SYNC_AUTOREPEAT_EN
    localparam int            RW       = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RW-1:0] TGT_DLY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] TGT_RATE = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_phase;
    logic          r_rpt;
    logic          w_hold;
    logic [RW-1:0] w_rep_tgt;

    // Repeats count only while the FSM stays in S_HIGH; any exit clears them.
    assign w_hold    = (r_state == S_HIGH) && (w_state_nxt == S_HIGH);
    assign w_rep_tgt = r_rep_phase ? TGT_RATE : TGT_DLY;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
            r_rpt       <= 1'b0;
        end else if (!w_hold) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
            r_rpt       <= 1'b0;
        end else if (r_rep_cnt == w_rep_tgt) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
            r_rpt       <= 1'b1;
        end else begin
            r_rep_cnt   <= (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + RW'(1);
            r_rpt       <= 1'b0;
        end
    end

    assign rpt = r_rpt;
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of N_CH independent debounced inputs with rise/fall pulses.
// Define SYNC_AUTOREPEAT_EN to build the per-channel auto-repeat outputs.
module sync_debounce_bank
    import sync_pkg::*;
#(
    parameter int N_CH            = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int INVERT          = 1,
    parameter int REPEAT_DELAY    = 1024,
    parameter int REPEAT_RATE     = 256
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] d,
    output logic [N_CH-1:0] q,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] rpt
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sync_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .Clk   (Clk),
            .Reset (Reset),
            .d     (d[g]),
            .q     (q[g]),
            .rise  (rise[g]),
            .fall  (fall[g]),
            .rpt   (rpt[g])
        );
    end

endmodule
